// File: rtl/np0_csr_pkg.sv
// Shared definitions for the np0 CSR register file: the bus request bundle,
// the decode-miss read value and the register map offsets.
package np0_csr_pkg;

    localparam int CSR_AWIDTH   = 16;
    localparam int CSR_DWIDTH   = 32;
    localparam int CSR_NUM_CTRL = 4;
    localparam int CSR_NUM_STAT = 2;

    // EVT sits right after the status block; IRQ_EN follows EVT.
    localparam int OFS_EVT    = CSR_NUM_CTRL + CSR_NUM_STAT;
    localparam int OFS_IRQ_EN = OFS_EVT + 1;

    localparam logic [31:0] ADDR_DECODE_ERROR = 32'hDEADBEEF;

    typedef struct packed {
        logic                      req;
        logic                      wr;
        logic [CSR_AWIDTH-1:0]     addr;
        logic [CSR_DWIDTH-1:0]     wdata;
        logic [CSR_DWIDTH/8-1:0]   be;
    } np_bus_req_t;

    typedef struct packed {
        logic                  hit;
        logic [CSR_AWIDTH-1:0] idx;
    } csr_ofs_t;

    // hit is cleared below the base so the subtraction can never wrap into the map.
    function automatic csr_ofs_t csr_offset(input logic [CSR_AWIDTH-1:0] addr,
                                            input logic [CSR_AWIDTH-1:0] base);
        csr_ofs_t r;
        r.hit = (addr >= base);
        r.idx = addr - base;
        return r;
    endfunction

endpackage

// File: rtl/np0_csr_w1c_reg.sv
// Sticky event register: bits set from event pulses, cleared by byte-enabled
// write-1-to-clear; a same-cycle set beats the clear.
module np0_csr_w1c_reg #(
    parameter int NP_DWIDTH = 32
) (
    input  logic                   np_clk,
    input  logic                   np_rst,
    input  logic [NP_DWIDTH-1:0]   set_i,
    input  logic                   clr_en_i,
    input  logic [NP_DWIDTH-1:0]   clr_data_i,
    input  logic [NP_DWIDTH/8-1:0] clr_be_i,
    output logic [NP_DWIDTH-1:0]   val_d_o,
    output logic [NP_DWIDTH-1:0]   val_q_o
);

    logic [NP_DWIDTH-1:0] val_q;
    logic [NP_DWIDTH-1:0] val_d;
    logic [NP_DWIDTH-1:0] clr_mask;

    always_comb begin
        clr_mask = '0;
        if (clr_en_i) begin
            for (int b = 0; b < NP_DWIDTH/8; b++) begin
                clr_mask[b*8 +: 8] = clr_data_i[b*8 +: 8] & {8{clr_be_i[b]}};
            end
        end
        val_d = (val_q & ~clr_mask) | set_i;
    end

    always_ff @(posedge np_clk) begin
        if (np_rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val_d_o = val_d;
    assign val_q_o = val_q;

endmodule

// File: rtl/np0_csr_regfile.sv
// Parametrised CSR engine: CTRL (RW), STAT (RO), EVT (RW1C) and IRQ_EN (RW)
// behind a single-cycle registered CPU bus response, with a level interrupt.
module np0_csr_regfile
    import np0_csr_pkg::*;
#(
    parameter int                  NP_AWIDTH    = CSR_AWIDTH,
    parameter int                  NP_DWIDTH    = CSR_DWIDTH,
    parameter int unsigned         BASE_ADDR    = 'h0020,
    parameter int                  NUM_CTRL     = CSR_NUM_CTRL,
    parameter int                  NUM_STAT     = CSR_NUM_STAT,
    parameter logic [NP_DWIDTH-1:0] CTRL_RST_VAL = '0
) (
    input  logic                            np_clk,
    input  logic                            np_rst,
    input  logic                            np_req,
    input  logic                            np_wr,
    input  logic [NP_AWIDTH-1:0]            np_addr,
    input  logic [NP_DWIDTH-1:0]            np_wdata,
    input  logic [NP_DWIDTH/8-1:0]          np_be,
    output logic                            np_ack,
    output logic [NP_DWIDTH-1:0]            np_rdata,
    output logic                            np_err,
    output logic [NUM_CTRL*NP_DWIDTH-1:0]   ctrl_o,
    input  logic [NUM_STAT*NP_DWIDTH-1:0]   stat_i,
    input  logic [NP_DWIDTH-1:0]            evt_i,
    output logic                            irq
);

    localparam int EVT_OFS    = NUM_CTRL + NUM_STAT;
    localparam int IRQ_EN_OFS = EVT_OFS + 1;

    np_bus_req_t          bus;
    csr_ofs_t             dec;
    logic [NP_DWIDTH-1:0] be_mask;
    logic                 sel_ctrl, sel_stat, sel_evt, sel_irq_en, miss;

    logic [NP_DWIDTH-1:0] ctrl_q [NUM_CTRL];
    logic [NP_DWIDTH-1:0] ctrl_d [NUM_CTRL];
    logic [NP_DWIDTH-1:0] irq_en_q, irq_en_d;
    logic [NP_DWIDTH-1:0] evt_q, evt_d;
    logic                 evt_clr_en;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic [NP_DWIDTH-1:0] rdata_q, rdata_d;
    logic                 irq_q, irq_d;

    assign bus = '{req: np_req, wr: np_wr, addr: np_addr, wdata: np_wdata, be: np_be};
    assign dec = csr_offset(bus.addr, NP_AWIDTH'(BASE_ADDR));

    always_comb begin
        sel_ctrl   = dec.hit && (dec.idx < NP_AWIDTH'(NUM_CTRL));
        sel_stat   = dec.hit && (dec.idx >= NP_AWIDTH'(NUM_CTRL)) && (dec.idx < NP_AWIDTH'(EVT_OFS));
        sel_evt    = dec.hit && (dec.idx == NP_AWIDTH'(EVT_OFS));
        sel_irq_en = dec.hit && (dec.idx == NP_AWIDTH'(IRQ_EN_OFS));
        miss       = !(sel_ctrl || sel_stat || sel_evt || sel_irq_en);
        for (int b = 0; b < NP_DWIDTH/8; b++) begin
            be_mask[b*8 +: 8] = {8{bus.be[b]}};
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CTRL; i++) begin
            ctrl_d[i] = ctrl_q[i];
            if (bus.req && bus.wr && sel_ctrl && (dec.idx == NP_AWIDTH'(i))) begin
                ctrl_d[i] = (ctrl_q[i] & ~be_mask) | (bus.wdata & be_mask);
            end
        end
        irq_en_d = irq_en_q;
        if (bus.req && bus.wr && sel_irq_en) begin
            irq_en_d = (irq_en_q & ~be_mask) | (bus.wdata & be_mask);
        end
        evt_clr_en = bus.req && bus.wr && sel_evt;
        irq_d      = |(evt_d & irq_en_d);
    end

    np0_csr_w1c_reg #(
        .NP_DWIDTH (NP_DWIDTH)
    ) u_evt (
        .np_clk     (np_clk),
        .np_rst     (np_rst),
        .set_i      (evt_i),
        .clr_en_i   (evt_clr_en),
        .clr_data_i (bus.wdata),
        .clr_be_i   (bus.be),
        .val_d_o    (evt_d),
        .val_q_o    (evt_q)
    );

    // Reads return pre-update flop values; writes acknowledge with zero data.
    always_comb begin
        ack_d   = bus.req;
        err_d   = 1'b0;
        rdata_d = '0;
        if (bus.req) begin
            if (miss) begin
                err_d   = 1'b1;
                rdata_d = NP_DWIDTH'(ADDR_DECODE_ERROR);
            end else if (bus.wr) begin
                err_d = sel_stat;
            end else begin
                for (int i = 0; i < NUM_CTRL; i++) begin
                    if (dec.idx == NP_AWIDTH'(i)) rdata_d = ctrl_q[i];
                end
                for (int i = 0; i < NUM_STAT; i++) begin
                    if (dec.idx == NP_AWIDTH'(NUM_CTRL + i)) rdata_d = stat_i[i*NP_DWIDTH +: NP_DWIDTH];
                end
                if (sel_evt)    rdata_d = evt_q;
                if (sel_irq_en) rdata_d = irq_en_q;
            end
        end
    end

    always_ff @(posedge np_clk) begin
        if (np_rst) begin
            for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= CTRL_RST_VAL;
            irq_en_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= ctrl_d[i];
            irq_en_q <= irq_en_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_o
        assign ctrl_o[g*NP_DWIDTH +: NP_DWIDTH] = ctrl_q[g];
    end

    assign np_ack   = ack_q;
    assign np_err   = err_q;
    assign np_rdata = rdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_np0_csr_regfile.sv
// Directed self-checking bench for np0_csr_regfile: reset, byte writes, decode
// misses, status access, sticky events with interrupt, and streaming with reset.
module tb_np0_csr_regfile;

    localparam logic [15:0] A_CTRL0  = 16'h0020;
    localparam logic [15:0] A_CTRL1  = 16'h0021;
    localparam logic [15:0] A_CTRL2  = 16'h0022;
    localparam logic [15:0] A_STAT0  = 16'h0024;
    localparam logic [15:0] A_STAT1  = 16'h0025;
    localparam logic [15:0] A_EVT    = 16'h0026;
    localparam logic [15:0] A_IRQ_EN = 16'h0027;

    logic         np_clk = 1'b0;
    logic         np_rst;
    logic         np_req;
    logic         np_wr;
    logic [15:0]  np_addr;
    logic [31:0]  np_wdata;
    logic [3:0]   np_be;
    logic         np_ack;
    logic [31:0]  np_rdata;
    logic         np_err;
    logic [127:0] ctrl_o;
    logic [63:0]  stat_i;
    logic [31:0]  evt_i;
    logic         irq;

    int checks = 0;
    int errors = 0;

    always #5 np_clk = ~np_clk;

    np0_csr_regfile dut (
        .np_clk   (np_clk),
        .np_rst   (np_rst),
        .np_req   (np_req),
        .np_wr    (np_wr),
        .np_addr  (np_addr),
        .np_wdata (np_wdata),
        .np_be    (np_be),
        .np_ack   (np_ack),
        .np_rdata (np_rdata),
        .np_err   (np_err),
        .ctrl_o   (ctrl_o),
        .stat_i   (stat_i),
        .evt_i    (evt_i),
        .irq      (irq)
    );

    // Present one cycle of bus inputs; returns 1 time unit after the sampling edge.
    task automatic drive(input logic req, input logic wr, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        np_req   = req;
        np_wr    = wr;
        np_addr  = addr;
        np_wdata = wdata;
        np_be    = be;
        @(posedge np_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] a;
        np_rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, A_CTRL0, 32'h0, 4'h0);
        checks++;
        if (np_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_drop_ack: got %b want 0", np_ack);
        end
        np_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = A_CTRL0 + 16'(i);
            drive(1'b1, 1'b0, a, 32'h0, 4'h0);
            checks++;
            if (np_ack !== 1'b1 || np_rdata !== 32'h0 || np_err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_ctrl%0d: ack=%b rdata=%h err=%b want ack=1 rdata=0 err=0",
                         i, np_ack, np_rdata, np_err);
            end
        end
        drive(1'b1, 1'b0, A_EVT, 32'h0, 4'h0);
        checks++;
        if (np_rdata !== 32'h0 || np_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_evt: rdata=%h err=%b want 0 0", np_rdata, np_err);
        end
        drive(1'b1, 1'b0, A_IRQ_EN, 32'h0, 4'h0);
        checks++;
        if (np_rdata !== 32'h0 || np_err !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_irq_en: rdata=%h err=%b irq=%b want 0 0 0", np_rdata, np_err, irq);
        end
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    endtask

    task automatic test_byte_write();
        drive(1'b1, 1'b1, A_CTRL1, 32'hA5A5_A5A5, 4'b0101);
        checks++;
        if (np_ack !== 1'b1 || np_err !== 1'b0 || ctrl_o[32 +: 32] !== 32'h00A5_00A5) begin
            errors++;
            $display("[TB] FAIL byte_write: ack=%b err=%b ctrl1=%h want 1 0 00a500a5",
                     np_ack, np_err, ctrl_o[32 +: 32]);
        end
        drive(1'b1, 1'b0, A_CTRL1, 32'h0, 4'h0);
        checks++;
        if (np_ack !== 1'b1 || np_rdata !== 32'h00A5_00A5) begin
            errors++;
            $display("[TB] FAIL byte_read: ack=%b rdata=%h want 1 00a500a5", np_ack, np_rdata);
        end
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        checks++;
        if (np_ack !== 1'b0 || np_rdata !== 32'h0 || np_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_read: ack=%b rdata=%h err=%b want 0 0 0",
                     np_ack, np_rdata, np_err);
        end
    endtask

    task automatic test_decode_miss();
        drive(1'b1, 1'b0, 16'h0028, 32'h0, 4'h0);
        checks++;
        if (np_ack !== 1'b1 || np_rdata !== 32'hDEAD_BEEF || np_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL miss_above: ack=%b rdata=%h err=%b want 1 deadbeef 1", np_ack, np_rdata, np_err);
        end
        drive(1'b1, 1'b0, 16'h001F, 32'h0, 4'h0);
        checks++;
        if (np_ack !== 1'b1 || np_rdata !== 32'hDEAD_BEEF || np_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL miss_below: ack=%b rdata=%h err=%b want 1 deadbeef 1", np_ack, np_rdata, np_err);
        end
        drive(1'b1, 1'b1, 16'hFFFF, 32'hFFFF_FFFF, 4'hF);
        checks++;
        if (np_err !== 1'b1 || np_rdata !== 32'hDEAD_BEEF
            || ctrl_o !== 128'h0000_0000_0000_0000_00A5_00A5_0000_0000) begin
            errors++;
            $display("[TB] FAIL miss_write: err=%b rdata=%h ctrl=%h want 1 deadbeef ctrl unchanged",
                     np_err, np_rdata, ctrl_o);
        end
        drive(1'b1, 1'b0, A_IRQ_EN, 32'h0, 4'h0);
        checks++;
        if (np_rdata !== 32'h0 || np_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL miss_write_irq_en: rdata=%h err=%b want 0 0", np_rdata, np_err);
        end
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    endtask

    task automatic test_stat();
        stat_i = {32'hCAFE_F00D, 32'h1234_5678};
        drive(1'b1, 1'b0, A_STAT0, 32'h0, 4'h0);
        checks++;
        if (np_rdata !== 32'h1234_5678 || np_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stat0_read: rdata=%h err=%b want 12345678 0", np_rdata, np_err);
        end
        drive(1'b1, 1'b0, A_STAT1, 32'h0, 4'h0);
        checks++;
        if (np_rdata !== 32'hCAFE_F00D || np_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stat1_read: rdata=%h err=%b want cafef00d 0", np_rdata, np_err);
        end
        drive(1'b1, 1'b1, A_STAT0, 32'hFFFF_FFFF, 4'hF);
        checks++;
        if (np_ack !== 1'b1 || np_rdata !== 32'h0 || np_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stat_write: ack=%b rdata=%h err=%b want 1 0 1", np_ack, np_rdata, np_err);
        end
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    endtask

    task automatic test_irq_w1c();
        drive(1'b1, 1'b1, A_IRQ_EN, 32'h0000_0001, 4'hF);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_idle: irq=%b want 0", irq);
        end
        evt_i = 32'h1;
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        evt_i = 32'h0;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_assert: irq=%b want 1", irq);
        end
        drive(1'b1, 1'b1, A_EVT, 32'h0000_0001, 4'b1110);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL w1c_be_masked: irq=%b want 1", irq);
        end
        drive(1'b1, 1'b1, A_EVT, 32'h0000_0001, 4'hF);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL w1c_clear: irq=%b want 0", irq);
        end
        evt_i = 32'h1;
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b1, A_EVT, 32'h0000_0001, 4'hF);
        evt_i = 32'h0;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL set_wins_irq: irq=%b want 1", irq);
        end
        drive(1'b1, 1'b0, A_EVT, 32'h0, 4'h0);
        checks++;
        if (np_rdata !== 32'h0000_0001 || irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL set_wins_evt: rdata=%h irq=%b want 00000001 1", np_rdata, irq);
        end
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    endtask

    task automatic test_streaming();
        logic [31:0] last_wr;
        logic [31:0] val;
        last_wr = 32'h0;
        for (int k = 0; k < 8; k++) begin
            val = 32'h1000_0000 + 32'(k);
            if (k % 2 == 0) begin
                drive(1'b1, 1'b1, A_CTRL2, val, 4'hF);
                checks++;
                if (np_ack !== 1'b1 || ctrl_o[64 +: 32] !== val) begin
                    errors++;
                    $display("[TB] FAIL stream_wr%0d: ack=%b ctrl2=%h want 1 %h", k, np_ack, ctrl_o[64 +: 32], val);
                end
                last_wr = val;
            end else begin
                drive(1'b1, 1'b0, A_CTRL2, 32'h0, 4'h0);
                checks++;
                if (np_ack !== 1'b1 || np_rdata !== last_wr) begin
                    errors++;
                    $display("[TB] FAIL stream_rd%0d: ack=%b rdata=%h want 1 %h", k, np_ack, np_rdata, last_wr);
                end
            end
        end
        drive(1'b1, 1'b1, A_CTRL2, 32'h1111_1111, 4'hF);
        drive(1'b1, 1'b0, A_CTRL2, 32'h0, 4'h0);
        drive(1'b1, 1'b1, A_CTRL2, 32'h2222_2222, 4'hF);
        np_rst = 1'b1;
        drive(1'b1, 1'b0, A_CTRL2, 32'h0, 4'h0);
        checks++;
        if (np_ack !== 1'b0 || ctrl_o !== 128'h0 || irq !== 1'b0 || np_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL stream_reset: ack=%b ctrl=%h irq=%b rdata=%h want 0 0 0 0",
                     np_ack, ctrl_o, irq, np_rdata);
        end
        np_rst = 1'b0;
        drive(1'b1, 1'b0, A_EVT, 32'h0, 4'h0);
        checks++;
        if (np_ack !== 1'b1 || np_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL post_reset_evt: ack=%b rdata=%h want 1 0", np_ack, np_rdata);
        end
        drive(1'b1, 1'b0, A_IRQ_EN, 32'h0, 4'h0);
        checks++;
        if (np_ack !== 1'b1 || np_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL post_reset_irq_en: ack=%b rdata=%h want 1 0", np_ack, np_rdata);
        end
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    endtask

    initial begin
        np_rst   = 1'b1;
        np_req   = 1'b0;
        np_wr    = 1'b0;
        np_addr  = 16'h0;
        np_wdata = 32'h0;
        np_be    = 4'h0;
        stat_i   = 64'h0;
        evt_i    = 32'h0;
        test_reset();
        test_byte_write();
        test_decode_miss();
        test_stat();
        test_irq_w1c();
        test_streaming();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
